// File: rtl/ttab_pkg.sv
// Shared helpers for the AES T-table round-combine stage: byte selection,
// column-count legality and beats-per-block derivation.
package ttab_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COL_T_W = 128;

  // Only 1, 2 or 4 columns per beat divide a 4-column state evenly.
  function automatic bit cols_legal(input int unsigned cols);
    return (cols == 1) || (cols == 2) || (cols == 4);
  endfunction

  function automatic int unsigned beats_of(input int unsigned cols);
    return (cols == 0) ? 1 : 4 / cols;
  endfunction

  // Picks the byte of a {2s, s, s, 3s} word that lands on a row offset d.
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] d);
    logic [7:0] b;
    case (d)
      2'd0:    b = word[31:24];
      2'd1:    b = word[7:0];
      2'd2:    b = word[15:8];
      default: b = word[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ttab_col_mix.sv
// Combinational combine of one state column: MixColumns XOR of four T-table
// words (or the bare S-box byte in the final round) plus AddRoundKey.
module ttab_col_mix
  import ttab_pkg::*;
(
  input  logic [COL_T_W-1:0] t,
  input  logic [WORD_W-1:0]  key,
  input  logic               last,
  output logic [WORD_W-1:0]  mixed_c
);

  always_comb begin
    mixed_c = key;
    for (int i = 0; i < 4; i++) begin
      if (last) begin
        // Middle byte of word i is the plain S-box output.
        mixed_c[31-8*i -: 8] = mixed_c[31-8*i -: 8] ^ t[127-32*i-8 -: 8];
      end else begin
        for (int r = 0; r < 4; r++) begin
          mixed_c[31-8*i -: 8] = mixed_c[31-8*i -: 8]
                                 ^ sel_byte(t[127-32*r -: 32], 2'(r - i));
        end
      end
    end
  end

endmodule

// File: rtl/ttab_round_combine.sv
// Handshaked round-combine stage: assembles a 128-bit AES state from beats
// of COLS combined columns and hands it downstream with a block counter.
module ttab_round_combine
  import ttab_pkg::*;
#(
  parameter int unsigned COLS  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COLS*COL_T_W-1:0] in_t,
  input  logic [COLS*WORD_W-1:0]  in_key,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STATE_W-1:0]      out_state,
  output logic                    out_last,
  output logic [CNT_W-1:0]        blk_cnt
);

  localparam bit          COLS_OK = cols_legal(COLS);
  localparam int unsigned BEATS   = beats_of(COLS);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned MIX_W   = COLS * WORD_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (!COLS_OK) begin : g_bad_cols
    $error("ttab_round_combine: COLS must be 1, 2 or 4");
  end

  logic [BEAT_W-1:0]  beat_q;
  logic               mode_q;
  logic               final_beat_c;
  logic               blk_last_c;
  logic               accept_c;
  logic               final_acc_c;
  logic               xfer_c;
  logic [MIX_W-1:0]   mix_c;
  logic [STATE_W-1:0] next_state_c;

  // Mode comes straight from the input on the first beat, else from the latch.
  assign final_beat_c = (beat_q == LAST_BEAT);
  assign blk_last_c   = (beat_q == '0) ? in_last : mode_q;
  assign in_ready     = !flush && !(final_beat_c && out_valid && !out_ready);
  assign accept_c     = in_valid && in_ready;
  assign final_acc_c  = accept_c && final_beat_c;
  assign xfer_c       = out_valid && out_ready;

  for (genvar k = 0; k < COLS; k++) begin : g_col
    ttab_col_mix u_mix (
      .t       (in_t[(COLS-k)*COL_T_W-1 -: COL_T_W]),
      .key     (in_key[(COLS-k)*WORD_W-1 -: WORD_W]),
      .last    (blk_last_c),
      .mixed_c (mix_c[(COLS-k)*WORD_W-1 -: WORD_W])
    );
  end

  // Partial-block assembly; the final beat's columns bypass it into the output.
  if (BEATS > 1) begin : g_asm
    localparam int unsigned ASM_W = STATE_W - MIX_W;
    logic [ASM_W-1:0] asm_q;
    int unsigned      base_c;

    assign base_c = ASM_W - 1 - WORD_W * COLS * 32'(beat_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        asm_q <= '0;
      end else if (accept_c && !final_beat_c) begin
        for (int unsigned k = 0; k < COLS; k++) begin
          asm_q[base_c - WORD_W*k -: WORD_W] <= mix_c[(COLS-k)*WORD_W-1 -: WORD_W];
        end
      end
    end

    assign next_state_c = {asm_q, mix_c};
  end else begin : g_direct
    assign next_state_c = mix_c;
  end

  // Beat counter and latched block mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      mode_q <= 1'b0;
    end else if (flush) begin
      beat_q <= '0;
      mode_q <= 1'b0;
    end else if (accept_c) begin
      if (beat_q == '0) mode_q <= in_last;
      beat_q <= final_beat_c ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // Output register: a final beat reloads it even while the old block leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_last  <= 1'b0;
    end else if (final_acc_c) begin
      out_valid <= 1'b1;
      out_state <= next_state_c;
      out_last  <= blk_last_c;
    end else if (xfer_c) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_cnt <= '0;
    else if (xfer_c) blk_cnt <= blk_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ttab_round_combine.sv
// Directed self-checking bench for ttab_round_combine at COLS = 4, 1 and 2.
module tb_ttab_round_combine;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // COLS=4, 2-bit counter
  logic         a_flush, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [511:0] a_in_t;
  logic [127:0] a_in_key, a_out_state;
  logic [1:0]   a_blk_cnt;
  // COLS=1
  logic         b_flush, b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [127:0] b_in_t, b_out_state;
  logic [31:0]  b_in_key;
  logic [15:0]  b_blk_cnt;
  // COLS=2
  logic         c_flush, c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_last;
  logic [255:0] c_in_t;
  logic [63:0]  c_in_key;
  logic [127:0] c_out_state;
  logic [15:0]  c_blk_cnt;

  ttab_round_combine #(.COLS(4), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_t(a_in_t), .in_key(a_in_key), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_state(a_out_state), .out_last(a_out_last), .blk_cnt(a_blk_cnt));

  ttab_round_combine #(.COLS(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_t(b_in_t), .in_key(b_in_key), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_state(b_out_state), .out_last(b_out_last), .blk_cnt(b_blk_cnt));

  ttab_round_combine #(.COLS(2), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_t(c_in_t), .in_key(c_in_key), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_state(c_out_state), .out_last(c_out_last), .blk_cnt(c_blk_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic a_send(input logic [511:0] t, input logic [127:0] k, input logic last);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_t = t; a_in_key = k; a_in_last = last;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [127:0] t, input logic [31:0] k, input logic last);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_t = t; b_in_key = k; b_in_last = last;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic c_send(input logic [255:0] t, input logic [63:0] k, input logic last);
    @(negedge clk);
    c_in_valid = 1'b1; c_in_t = t; c_in_key = k; c_in_last = last;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", a_out_valid); end
    tests++; if (a_out_state !== 128'h0) begin fails++; $display("FAIL reset_state got %h want 0", a_out_state); end
    tests++; if (a_out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", a_out_last); end
    tests++; if (a_blk_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", a_blk_cnt); end
    tests++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid_bc got %b%b want 00", b_out_valid, c_out_valid); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", a_in_ready); end
  endtask

  task automatic test_normal();
    a_send({32'hC66363A5, 480'h0}, 128'h0, 1'b0);
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL normal_valid got %b want 1", a_out_valid); end
    tests++; if (a_out_state !== {32'hC66363A5, 96'h0}) begin
      fails++; $display("FAIL normal_state got %h want %h", a_out_state, {32'hC66363A5, 96'h0}); end
    tests++; if (a_out_last !== 1'b0) begin fails++; $display("FAIL normal_last got %b want 0", a_out_last); end
    @(posedge clk); #1;
    tests++; if (a_out_valid !== 1'b0 || a_blk_cnt !== 2'd1) begin
      fails++; $display("FAIL normal_xfer got valid=%b cnt=%0d want 0/1", a_out_valid, a_blk_cnt); end
  endtask

  task automatic test_final();
    a_send({32'hC66363A5, 480'h0}, 128'h0, 1'b1);
    tests++; if (a_out_state !== {32'h63000000, 96'h0}) begin
      fails++; $display("FAIL final_state got %h want %h", a_out_state, {32'h63000000, 96'h0}); end
    tests++; if (a_out_last !== 1'b1) begin fails++; $display("FAIL final_last got %b want 1", a_out_last); end
    @(posedge clk); #1;
    tests++; if (a_blk_cnt !== 2'd2) begin fails++; $display("FAIL final_cnt got %0d want 2", a_blk_cnt); end
  endtask

  task automatic test_columns();
    // column 1, word 1 = 11223344, key FFFFFFFF -> 44112233 ^ FFFFFFFF
    a_send({128'h0, 32'h0, 32'h11223344, 64'h0, 256'h0}, {32'h0, 32'hFFFFFFFF, 64'h0}, 1'b0);
    tests++; if (a_out_state !== {32'h0, 32'hBBEEDDCC, 64'h0}) begin
      fails++; $display("FAIL col1_state got %h want %h", a_out_state, {32'h0, 32'hBBEEDDCC, 64'h0}); end
    @(posedge clk); #1;
    tests++; if (a_blk_cnt !== 2'd3) begin fails++; $display("FAIL col1_cnt got %0d want 3", a_blk_cnt); end
  endtask

  task automatic test_wrap();
    a_send(512'h0, 128'h1, 1'b0);
    @(posedge clk); #1;
    tests++; if (a_blk_cnt !== 2'd0) begin fails++; $display("FAIL wrap_cnt got %0d want 0", a_blk_cnt); end
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL wrap_valid got %b want 0", a_out_valid); end
  endtask

  task automatic test_key_only();
    b_send(128'h0, 32'h00010203, 1'b0);
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL key_early1 got %b want 0", b_out_valid); end
    b_send(128'h0, 32'h04050607, 1'b1);
    b_send(128'h0, 32'h08090A0B, 1'b0);
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL key_early3 got %b want 0", b_out_valid); end
    b_send(128'h0, 32'h0C0D0E0F, 1'b1);
    tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL key_valid got %b want 1", b_out_valid); end
    tests++; if (b_out_state !== 128'h000102030405060708090A0B0C0D0E0F) begin
      fails++; $display("FAIL key_state got %h want 000102030405060708090a0b0c0d0e0f", b_out_state); end
    tests++; if (b_out_last !== 1'b0) begin fails++; $display("FAIL key_last got %b want 0", b_out_last); end
    @(posedge clk); #1;
    tests++; if (b_blk_cnt !== 16'd1) begin fails++; $display("FAIL key_cnt got %0d want 1", b_blk_cnt); end
  endtask

  task automatic test_mode_latch();
    // final mode on word1 = 00AB0000 yields 00AB0000 (normal would be 0000AB00)
    b_send({32'h0, 32'h00AB0000, 64'h0}, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) b_send({32'h0, 32'h00AB0000, 64'h0}, 32'h0, 1'b0);
    tests++; if (b_out_state !== {4{32'h00AB0000}}) begin
      fails++; $display("FAIL latch_state got %h want %h", b_out_state, {4{32'h00AB0000}}); end
    tests++; if (b_out_last !== 1'b1) begin fails++; $display("FAIL latch_last got %b want 1", b_out_last); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    b_send(128'h0, 32'hDEADBEEF, 1'b1);
    b_send(128'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_key = 32'hBAD0BAD0; b_in_last = 1'b0;
    #1;
    tests++; if (b_in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b want 0", b_in_ready); end
    @(posedge clk); #1;
    b_flush = 1'b0; b_in_valid = 1'b0;
    tests++; if (b_blk_cnt !== 16'd2 || b_out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_hold got cnt=%0d valid=%b want 2/0", b_blk_cnt, b_out_valid); end
    b_send(128'h0, 32'h11111111, 1'b0);
    b_send(128'h0, 32'h22222222, 1'b0);
    b_send(128'h0, 32'h33333333, 1'b0);
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL flush_early got %b want 0", b_out_valid); end
    b_send(128'h0, 32'h44444444, 1'b0);
    tests++; if (b_out_state !== 128'h11111111222222223333333344444444 || b_out_last !== 1'b0) begin
      fails++; $display("FAIL flush_state got %h last=%b want 11111111222222223333333344444444 last=0",
                        b_out_state, b_out_last); end
    @(posedge clk); #1;
    tests++; if (b_blk_cnt !== 16'd3) begin fails++; $display("FAIL flush_cnt got %0d want 3", b_blk_cnt); end
  endtask

  task automatic test_back_pressure();
    c_out_ready = 1'b0;
    c_send(256'h0, {32'hA0A0A0A0, 32'hA1A1A1A1}, 1'b0);
    c_send(256'h0, {32'hA2A2A2A2, 32'hA3A3A3A3}, 1'b0);
    tests++; if (c_out_valid !== 1'b1 || c_out_state !== 128'hA0A0A0A0A1A1A1A1A2A2A2A2A3A3A3A3) begin
      fails++; $display("FAIL bp_blockA got valid=%b state=%h", c_out_valid, c_out_state); end
    @(negedge clk);
    c_in_valid = 1'b1; c_in_t = 256'h0; c_in_key = {32'hB0B0B0B0, 32'hB1B1B1B1}; c_in_last = 1'b0;
    #1;
    tests++; if (c_in_ready !== 1'b1) begin fails++; $display("FAIL bp_beat0_ready got %b want 1", c_in_ready); end
    @(posedge clk); #1;
    c_in_key = {32'hB2B2B2B2, 32'hB3B3B3B3};
    tests++; if (c_in_ready !== 1'b0) begin fails++; $display("FAIL bp_beat1_ready got %b want 0", c_in_ready); end
    @(posedge clk); #1;
    tests++; if (c_out_state !== 128'hA0A0A0A0A1A1A1A1A2A2A2A2A3A3A3A3 || c_out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_stable got valid=%b state=%h", c_out_valid, c_out_state); end
    @(negedge clk);
    c_out_ready = 1'b1;
    #1;
    tests++; if (c_in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", c_in_ready); end
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    tests++; if (c_out_valid !== 1'b1 || c_out_state !== 128'hB0B0B0B0B1B1B1B1B2B2B2B2B3B3B3B3) begin
      fails++; $display("FAIL bp_blockB got valid=%b state=%h", c_out_valid, c_out_state); end
    tests++; if (c_blk_cnt !== 16'd1) begin fails++; $display("FAIL bp_cnt1 got %0d want 1", c_blk_cnt); end
    @(posedge clk); #1;
    tests++; if (c_out_valid !== 1'b0 || c_blk_cnt !== 16'd2) begin
      fails++; $display("FAIL bp_cnt2 got valid=%b cnt=%0d want 0/2", c_out_valid, c_blk_cnt); end
  endtask

  task automatic test_back_to_back();
    // word2 of column 3 = 12345678 maps to 56781234
    c_send({32'hC66363A5, 224'h0}, {32'h0, 32'h01010101}, 1'b0);
    c_send({128'h0, 64'h0, 32'h12345678, 32'h0}, 64'h0, 1'b0);
    tests++; if (c_out_valid !== 1'b1 || c_out_state !== 128'hC66363A5010101010000000056781234) begin
      fails++; $display("FAIL b2b_C got valid=%b state=%h", c_out_valid, c_out_state); end
    c_send(256'h0, {32'hD0D0D0D0, 32'hD1D1D1D1}, 1'b0);
    tests++; if (c_out_valid !== 1'b0 || c_blk_cnt !== 16'd3) begin
      fails++; $display("FAIL b2b_mid got valid=%b cnt=%0d want 0/3", c_out_valid, c_blk_cnt); end
    c_send(256'h0, {32'hD2D2D2D2, 32'hD3D3D3D3}, 1'b1);
    tests++; if (c_out_valid !== 1'b1 || c_out_state !== 128'hD0D0D0D0D1D1D1D1D2D2D2D2D3D3D3D3
                 || c_out_last !== 1'b0) begin
      fails++; $display("FAIL b2b_D got valid=%b last=%b state=%h", c_out_valid, c_out_last, c_out_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_send(512'h0, {4{32'h5A5A5A5A}}, 1'b1);
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre got %b want 1", a_out_valid); end
    b_send(128'h0, 32'hEEEEEEEE, 1'b0);
    b_send(128'h0, 32'hEEEEEEEE, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++; if (a_out_valid !== 1'b0 || a_out_state !== 128'h0 || a_out_last !== 1'b0) begin
      fails++; $display("FAIL ar_clear got valid=%b last=%b state=%h", a_out_valid, a_out_last, a_out_state); end
    tests++; if (b_blk_cnt !== 16'd0) begin fails++; $display("FAIL ar_cnt got %0d want 0", b_blk_cnt); end
    @(negedge clk);
    rst_n = 1'b1; a_out_ready = 1'b1;
    b_send(128'h0, 32'hCAFE0001, 1'b0);
    b_send(128'h0, 32'hCAFE0002, 1'b0);
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL ar_residue got %b want 0", b_out_valid); end
    b_send(128'h0, 32'hCAFE0003, 1'b0);
    b_send(128'h0, 32'hCAFE0004, 1'b0);
    tests++; if (b_out_valid !== 1'b1 || b_out_state !== 128'hCAFE0001CAFE0002CAFE0003CAFE0004) begin
      fails++; $display("FAIL ar_block got valid=%b state=%h", b_out_valid, b_out_state); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_t = '0; a_in_key = '0; a_in_last = 0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_t = '0; b_in_key = '0; b_in_last = 0; b_out_ready = 1;
    c_flush = 0; c_in_valid = 0; c_in_t = '0; c_in_key = '0; c_in_last = 0; c_out_ready = 1;
    #7;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_normal();
    test_final();
    test_columns();
    test_wrap();
    test_key_only();
    test_mode_latch();
    test_flush();
    test_back_pressure();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ttab_round_combine.md
# ttab_round_combine

Parametrised, handshaked AES round-combine stage for the T-table datapath. Each block is one round. The stage accepts T-table lookup words for 1, 2 or 4 state columns per beat and applies the ShiftRows byte selection, MixColumns XOR and AddRoundKey. It assembles the full 128-bit state and presents it to the next round or the key-output stage. It adds a final-round mode (S-box byte only, no MixColumns), partial-block assembly, back-pressure, flush and a completed-block counter.

## Interface
- `COLS`, default 4: state columns per input beat. Legal values are 1, 2, 4. Beats per block are `BEATS = 4/COLS`.
- `CNT_W`, default 16: width of the completed-block counter.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards the partial assembly.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_t`  in  `COLS*128`  T-table words for `COLS` columns. Column k occupies `[(COLS-k)*128-1 -: 128]`. Word r (row r, post-ShiftRows lookup) of a column is at `[127-32r -: 32]` within the column. Each word is `{2s, s, s, 3s}`.
- `in_key`  in  `COLS*32`  round-key columns, same column ordering.
- `in_last`  in  1  final-round mode; sampled on the first beat of a block.
- `out_valid`  out  1  assembled state valid.
- `out_ready`  in  1  downstream accept.
- `out_state`  out  128  result; column 0 is in the MSBs.
- `out_last`  out  1  mode of the block in `out_state`.
- `blk_cnt`  out  `CNT_W`  completed blocks handed downstream; wraps.

## Operation
- **Byte select `sel(d)`:** d=(r-i) mod 4. d=0 selects `[31:24]`, d=1 selects `[7:0]`, d=2 selects `[15:8]`, d=3 selects `[23:16]`.
- **Normal mode:** output row i of a column = XOR over r=0..3 of `sel((r-i) mod 4)` of word r, XOR key byte i. Key byte 0 is the MSB.
- **Final mode:** output row i = `word_i[23:16]` XOR key byte i.
- **Beat counter `beat`** (0..BEATS-1):
  - Each accepted beat writes its `COLS` combined columns into the assembly register at column slots `beat*COLS ..`.
  - Mode is latched at `beat==0`; `in_last` on later beats is ignored.
  - The final beat (`beat==BEATS-1`) transfers the assembly, plus the current beat's columns, into the output register. It sets `out_valid` and `out_last` and returns `beat` to 0.
- **`in_ready`:** deasserted only when `beat==BEATS-1 && out_valid && !out_ready`. Non-final beats are always accepted, so assembly continues under output stall.
- **Output transfer:** `out_valid && out_ready` clears `out_valid` unless a final beat is accepted in the same cycle, in which case it stays high with the new data. `blk_cnt` increments on each output transfer and wraps from 2^CNT_W-1 to 0.
- **`flush`:**
  - Forces `beat` to 0 and drops the latched mode.
  - Does not affect the output register, `out_valid` or `blk_cnt`.
  - A beat presented with `flush` is not accepted; `in_ready` is 0 during `flush`.
- **COLS=4:** every beat is a final beat, so the assembly register is unused (optimised away).

## Timing
- **Reset values:** `out_valid`=0, `out_state`=0, `out_last`=0, `blk_cnt`=0, `beat`=0, assembly=0.
- **Latency:** final beat accepted at edge N gives `out_valid`=1 after edge N. The combine is combinational into the register.
- **Throughput:** one block per `BEATS` cycles with `out_ready` held high.
- **Data stability:** `out_state` and `out_last` are stable while `out_valid && !out_ready`.
- **Reset mid-block:** everything clears immediately; the partial block is lost.

## Structure
- **Package `ttab_pkg`:**
  - function `sel_byte(word, d)`.
  - localparam legality check for `COLS` (elaboration error otherwise).
  - `BEATS` derivation.
- **Sub-module `ttab_col_mix`:** combinational per-column combine with inputs 4×32 words, a 32-bit key and `last`, and a 32-bit output. The top instantiates `COLS` copies.
- The top holds the beat counter, assembly and output registers, handshake and counter.

## Test plan
- **Normal mode, single word:** COLS=4, key=0, word 0 of column 0 = 0xC66363A5, all others 0, `in_last`=0. Expect `out_state` = 0xC66363A5 followed by 96 zero bits, `out_valid` one cycle after accept, `blk_cnt`=1.
- **Final mode:** same stimulus with `in_last`=1. Expect `out_state` = 0x63000000 followed by 96 zero bits and `out_last`=1.
- **Key only:** COLS=1, all words 0, key columns 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F over 4 beats. Expect `out_state` = 0x000102030405060708090A0B0C0D0E0F after the 4th beat and not before. `in_last` toggled on beats 1–3 leaves `out_last`=0.
- **Back-pressure:** COLS=2, `out_ready`=0 with one block pending.
  - Beat 0 of the next block is accepted.
  - Beat 1 sees `in_ready`=0 until `out_ready`=1.
  - In the cycle `out_ready` rises, the final beat is accepted and `out_valid` stays 1 with the new state.
- **Flush:** COLS=1, flush after 2 beats. Expect the next 4 beats to form a complete block with no residue from the flushed beats, and `blk_cnt` unchanged by the flush.
- **Counter wrap and async reset:** with `CNT_W`=2, after 4 transfers `blk_cnt`=0. `rst_n` low mid-block clears `out_valid` asynchronously.
